// File: rtl/mips_mc_core.sv
// Multi-cycle MIPS core with FETCH/DECODE/EXEC/MEM/WB sequencing, private IM/DM/register file and a write-back trace.
// Optional feature: define MIPS_MC_JUMP_EN to add j/jal; otherwise those opcodes retire as nops.
module mips_mc_core #(
  parameter int          IM_DEPTH = 256,
  parameter int          DM_DEPTH = 32,
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        Im_we,
  input  logic [$clog2(IM_DEPTH)-1:0] Im_addr,
  input  logic [31:0]                 Im_wdata,
  output logic [31:0]                 Pc,
  output logic                        Halted,
  output logic                        Retire,
  output logic                        Wb_en,
  output logic [4:0]                  Wb_addr,
  output logic [31:0]                 Wb_data
);

  localparam int IM_AW = $clog2(IM_DEPTH);
  localparam int DM_AW = $clog2(DM_DEPTH);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
`ifdef MIPS_MC_JUMP_EN
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
`endif

  localparam logic [5:0] FN_SYSCALL = 6'h0C;
  localparam logic [5:0] FN_ADDU    = 6'h21;
  localparam logic [5:0] FN_SUBU    = 6'h23;
  localparam logic [5:0] FN_AND     = 6'h24;
  localparam logic [5:0] FN_OR      = 6'h25;
  localparam logic [5:0] FN_SLT     = 6'h2A;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  state_t      state;
  logic [31:0] im [IM_DEPTH];
  logic [31:0] rf [32];
  logic [31:0] dm [DM_DEPTH];
  logic [31:0] ir, a_reg, b_reg, imm_ext, br_target, alu_out, mdr;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, wb_dest;
  logic [15:0] imm;
  logic [31:0] imm_sext, imm_zext, r_result, wb_val;
  logic        funct_ok;

  assign opcode   = ir[31:26];
  assign rs       = ir[25:21];
  assign rt       = ir[20:16];
  assign rd       = ir[15:11];
  assign funct    = ir[5:0];
  assign imm      = ir[15:0];
  assign imm_sext = {{16{imm[15]}}, imm};
  assign imm_zext = {16'h0000, imm};
  assign wb_dest  = (opcode == OP_RTYPE) ? rd : rt;
  assign wb_val   = (opcode == OP_LW) ? mdr : alu_out;

  // R-type ALU; funct_ok flags the supported functs so anything else becomes a nop.
  always_comb begin
    r_result = 32'h0;
    funct_ok = 1'b1;
    case (funct)
      FN_ADDU: r_result = a_reg + b_reg;
      FN_SUBU: r_result = a_reg - b_reg;
      FN_AND:  r_result = a_reg & b_reg;
      FN_OR:   r_result = a_reg | b_reg;
      FN_SLT:  r_result = {31'h0, $signed(a_reg) < $signed(b_reg)};
      default: funct_ok = 1'b0;
    endcase
  end

  // Instruction memory is never reset; a same-cycle fetch of this word sees the old value.
  always_ff @(posedge Clk) begin
    if (Im_we) im[Im_addr] <= Im_wdata;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= S_FETCH;
      Pc        <= PC_RESET;
      Halted    <= 1'b0;
      Retire    <= 1'b0;
      Wb_en     <= 1'b0;
      Wb_addr   <= 5'd0;
      Wb_data   <= 32'h0;
      ir        <= 32'h0;
      a_reg     <= 32'h0;
      b_reg     <= 32'h0;
      imm_ext   <= 32'h0;
      br_target <= 32'h0;
      alu_out   <= 32'h0;
      mdr       <= 32'h0;
      for (int i = 0; i < 32; i++) rf[i] <= 32'h0;
      for (int i = 0; i < DM_DEPTH; i++) dm[i] <= 32'h0;
    end else begin
      Retire  <= 1'b0;
      Wb_en   <= 1'b0;
      Wb_addr <= 5'd0;
      Wb_data <= 32'h0;
      case (state)
        S_FETCH: begin
          ir    <= im[Pc[IM_AW+1:2]];
          Pc    <= Pc + 32'd4;
          state <= S_DECODE;
        end
        S_DECODE: begin
          a_reg     <= rf[rs];
          b_reg     <= rf[rt];
          imm_ext   <= (opcode == OP_ORI) ? imm_zext : imm_sext;
          br_target <= Pc + {imm_sext[29:0], 2'b00};
          state     <= S_EXEC;
        end
        S_EXEC: begin
          case (opcode)
            OP_RTYPE: begin
              if (funct == FN_SYSCALL) begin
                Halted <= 1'b1;
                Retire <= 1'b1;
                state  <= S_HALT;
              end else if (funct_ok) begin
                alu_out <= r_result;
                state   <= S_WB;
              end else begin
                Retire <= 1'b1;
                state  <= S_FETCH;
              end
            end
            OP_ORI: begin
              alu_out <= a_reg | imm_ext;
              state   <= S_WB;
            end
            OP_LUI: begin
              alu_out <= {imm, 16'h0000};
              state   <= S_WB;
            end
            OP_LW, OP_SW: begin
              alu_out <= a_reg + imm_ext;
              state   <= S_MEM;
            end
            OP_BEQ: begin
              if (a_reg == b_reg) Pc <= br_target;
              Retire <= 1'b1;
              state  <= S_FETCH;
            end
`ifdef MIPS_MC_JUMP_EN
            OP_J: begin
              Pc     <= {Pc[31:28], ir[25:0], 2'b00};
              Retire <= 1'b1;
              state  <= S_FETCH;
            end
            // jal links the already-incremented Pc into $31 straight from EXEC.
            OP_JAL: begin
              Pc      <= {Pc[31:28], ir[25:0], 2'b00};
              rf[31]  <= Pc;
              Wb_en   <= 1'b1;
              Wb_addr <= 5'd31;
              Wb_data <= Pc;
              Retire  <= 1'b1;
              state   <= S_FETCH;
            end
`endif
            default: begin
              Retire <= 1'b1;
              state  <= S_FETCH;
            end
          endcase
        end
        S_MEM: begin
          if (opcode == OP_LW) begin
            mdr   <= dm[alu_out[DM_AW+1:2]];
            state <= S_WB;
          end else begin
            dm[alu_out[DM_AW+1:2]] <= b_reg;
            Retire <= 1'b1;
            state  <= S_FETCH;
          end
        end
        S_WB: begin
          // $0 is never stored, so it keeps reading as zero.
          if (wb_dest != 5'd0) begin
            rf[wb_dest] <= wb_val;
            Wb_en       <= 1'b1;
            Wb_addr     <= wb_dest;
            Wb_data     <= wb_val;
          end
          Retire <= 1'b1;
          state  <= S_FETCH;
        end
        S_HALT: state <= S_HALT;
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_mc_core.sv
// Bench for mips_mc_core: directed and random programs checked against an instruction-level model.
module tb_mips_mc_core;

  localparam int          IM_DEPTH = 256;
  localparam int          DM_DEPTH = 32;
  localparam logic [31:0] PC_RESET = 32'h0000_0000;
  localparam logic [31:0] SYSCALL  = 32'h0000_000C;

  logic        Clk, Reset, Im_we;
  logic [7:0]  Im_addr;
  logic [31:0] Im_wdata, Pc, Wb_data;
  logic        Halted, Retire, Wb_en;
  logic [4:0]  Wb_addr;

  mips_mc_core #(.IM_DEPTH(IM_DEPTH), .DM_DEPTH(DM_DEPTH), .PC_RESET(PC_RESET)) dut (
    .Clk(Clk), .Reset(Reset), .Im_we(Im_we), .Im_addr(Im_addr), .Im_wdata(Im_wdata),
    .Pc(Pc), .Halted(Halted), .Retire(Retire), .Wb_en(Wb_en), .Wb_addr(Wb_addr), .Wb_data(Wb_data)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] tb_im [IM_DEPTH];
  logic [31:0] m_rf [32];
  logic [31:0] m_dm [DM_DEPTH];
  logic [31:0] m_pc;
  bit          m_halted;
  logic [31:0] prog [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  // Operand order follows assembly: op rt, rs, imm.
  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rt, input logic [4:0] rs, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] gen_random_instr();
    logic [5:0] fns [5] = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h2A};
    logic [4:0] ra = 5'($urandom_range(0, 7));
    logic [4:0] rb = 5'($urandom_range(0, 7));
    logic [4:0] rc = 5'($urandom_range(0, 7));
    logic [15:0] r16 = 16'($urandom);
    case ($urandom_range(0, 11))
      0, 1, 2, 3, 4: return enc_r(fns[$urandom_range(0, 4)], ra, rb, rc);
      5:  return enc_i(6'h0D, ra, rb, r16);
      6:  return enc_i(6'h0F, ra, 5'd0, r16);
      7:  return enc_i(6'h23, ra, rb, r16);
      8:  return enc_i(6'h2B, ra, rb, r16);
      9:  return enc_i(6'h04, 5'($urandom_range(0, 2)), 5'($urandom_range(0, 2)), 16'($urandom_range(0, 3)));
      10: return enc_i(6'h08, ra, rb, r16);
      default: return enc_r(6'h20, ra, rb, rc);
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
    for (int i = 0; i < DM_DEPTH; i++) m_dm[i] = 32'h0;
    m_pc = PC_RESET;
    m_halted = 1'b0;
  endtask

  // Executes one instruction architecturally and reports its cycle cost and register write.
  task automatic model_step(output int cyc, output bit wen, output logic [4:0] waddr, output logic [31:0] wdata);
    logic [31:0] w, a, b, sx, res, pc4, addr;
    logic [4:0]  dest;
    bit          wr;
    w    = tb_im[(m_pc >> 2) % IM_DEPTH];
    pc4  = m_pc + 4;
    m_pc = pc4;
    a    = m_rf[w[25:21]];
    b    = m_rf[w[20:16]];
    sx   = {{16{w[15]}}, w[15:0]};
    cyc  = 3; wr = 0; dest = 0; res = 0;
    case (w[31:26])
      6'h00: begin
        wr = 1; cyc = 4; dest = w[15:11];
        case (w[5:0])
          6'h21: res = a + b;
          6'h23: res = a - b;
          6'h24: res = a & b;
          6'h25: res = a | b;
          6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          6'h0C: begin wr = 0; cyc = 3; m_halted = 1; end
          default: begin wr = 0; cyc = 3; end
        endcase
      end
      6'h0D: begin wr = 1; cyc = 4; dest = w[20:16]; res = a | {16'h0, w[15:0]}; end
      6'h0F: begin wr = 1; cyc = 4; dest = w[20:16]; res = {w[15:0], 16'h0}; end
      6'h23: begin
        addr = a + sx;
        wr = 1; cyc = 5; dest = w[20:16]; res = m_dm[(addr >> 2) % DM_DEPTH];
      end
      6'h2B: begin
        addr = a + sx;
        cyc = 4; m_dm[(addr >> 2) % DM_DEPTH] = b;
      end
      6'h04: if (a == b) m_pc = pc4 + sx * 4;
`ifdef MIPS_MC_JUMP_EN
      6'h02: m_pc = {pc4[31:28], w[25:0], 2'b00};
      6'h03: begin m_pc = {pc4[31:28], w[25:0], 2'b00}; wr = 1; dest = 5'd31; res = pc4; end
`endif
      default: ;
    endcase
    wen = wr && (dest != 0);
    if (wen) m_rf[dest] = res;
    waddr = dest;
    wdata = res;
  endtask

  task automatic write_im(input int addr, input logic [31:0] data);
    Im_we = 1'b1; Im_addr = 8'(addr); Im_wdata = data;
    @(negedge Clk);
    Im_we = 1'b0;
    tb_im[addr] = data;
  endtask

  task automatic apply_stimulus();
    foreach (prog[i]) write_im(i, prog[i]);
    for (int i = 0; i < 4; i++) write_im(prog.size() + i, SYSCALL);
  endtask

  // Steps the core instruction by instruction, comparing each retirement against the model.
  task automatic check_output(input int max_instr, output int total);
    int cyc, exp_cyc;
    bit got, ew;
    logic [4:0] ea;
    logic [31:0] ed;
    total = 0;
    for (int n = 0; n < max_instr; n++) begin
      if (m_halted) break;
      model_step(exp_cyc, ew, ea, ed);
      cyc = 0; got = 0;
      while (!got && cyc < 12) begin
        @(posedge Clk); cyc++;
        @(negedge Clk);
        if (Retire === 1'b1) got = 1;
      end
      total += cyc;
      check("retire_seen", 32'(got), 32'd1);
      if (!got) break;
      check("cpi", cyc, exp_cyc);
      check("wb_en", 32'(Wb_en), 32'(ew));
      if (ew) begin
        check("wb_addr", 32'(Wb_addr), 32'(ea));
        check("wb_data", Wb_data, ed);
      end
      check("pc", Pc, m_pc);
      check("halted", 32'(Halted), 32'(m_halted));
    end
  endtask

  task automatic run_test(input int max_instr, output int total);
    Reset = 1'b1;
    @(negedge Clk);
    model_reset();
    apply_stimulus();
    Reset = 1'b0;
    check_output(max_instr, total);
  endtask

  task automatic check_halt_stable();
    for (int i = 0; i < 4; i++) begin
      @(posedge Clk);
      @(negedge Clk);
      check("halt_retire", 32'(Retire), 32'd0);
      check("halt_pc", Pc, m_pc);
      check("halt_flag", 32'(Halted), 32'd1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int total;
    Reset = 1'b1; Im_we = 1'b0; Im_addr = 8'd0; Im_wdata = 32'h0;
    @(negedge Clk);
    for (int i = 0; i < IM_DEPTH; i++) write_im(i, SYSCALL);

    check("rst_pc", Pc, PC_RESET);
    check("rst_halted", 32'(Halted), 32'd0);
    check("rst_retire", 32'(Retire), 32'd0);
    check("rst_wb_en", 32'(Wb_en), 32'd0);
    check("rst_wb_addr", 32'(Wb_addr), 32'd0);
    check("rst_wb_data", Wb_data, 32'd0);

    $display("[TB] basic ori/addu/syscall");
    prog = '{enc_i(6'h0D, 5'd1, 5'd0, 16'd5), enc_i(6'h0D, 5'd2, 5'd0, 16'd7),
             enc_r(6'h21, 5'd3, 5'd1, 5'd2), SYSCALL};
    run_test(10, total);
    check("prog1_cycles", total, 15);
    check("prog1_pc", Pc, 32'd16);
    check("prog1_r3", m_rf[3], 32'd12);
    check_halt_stable();

    $display("[TB] sw/lw round trip");
    prog = '{enc_i(6'h0F, 5'd3, 5'd0, 16'hDEAD), enc_i(6'h0D, 5'd3, 5'd3, 16'hBEEF),
             enc_i(6'h2B, 5'd3, 5'd0, 16'd4), enc_i(6'h23, 5'd4, 5'd0, 16'd4), SYSCALL};
    run_test(10, total);
    check("lw_r4", m_rf[4], 32'hDEAD_BEEF);

    $display("[TB] beq not taken, then self loop");
    prog = '{enc_i(6'h0D, 5'd1, 5'd0, 16'd1), enc_i(6'h04, 5'd2, 5'd1, 16'd1),
             enc_i(6'h04, 5'd1, 5'd1, 16'hFFFF)};
    run_test(8, total);
    check("beq_cycles", total, 25);
    check("beq_loop_pc", Pc, 32'd8);

    $display("[TB] lui/ori and writes to $0");
    prog = '{enc_i(6'h0F, 5'd5, 5'd0, 16'h1234), enc_i(6'h0D, 5'd5, 5'd5, 16'h8000),
             enc_i(6'h0D, 5'd1, 5'd0, 16'd3), enc_i(6'h0D, 5'd2, 5'd0, 16'd4),
             enc_r(6'h21, 5'd0, 5'd1, 5'd2), enc_r(6'h21, 5'd6, 5'd0, 5'd5), SYSCALL};
    run_test(10, total);
    check("lui_ori_r6", m_rf[6], 32'h1234_8000);

    $display("[TB] reset during sw MEM cycle");
    prog = '{enc_i(6'h0D, 5'd1, 5'd0, 16'h0055), enc_i(6'h2B, 5'd1, 5'd0, 16'd8),
             enc_i(6'h23, 5'd2, 5'd0, 16'd8), SYSCALL};
    Reset = 1'b1;
    @(negedge Clk);
    apply_stimulus();
    Reset = 1'b0;
    repeat (7) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    check("abort_pc", Pc, PC_RESET);
    check("abort_retire", 32'(Retire), 32'd0);
    check("abort_wb_en", 32'(Wb_en), 32'd0);
    model_reset();
    prog = '{enc_i(6'h23, 5'd2, 5'd0, 16'd8), enc_r(6'h21, 5'd3, 5'd1, 5'd0), SYSCALL};
    apply_stimulus();
    Reset = 1'b0;
    check_output(10, total);
    prog = '{enc_i(6'h0D, 5'd1, 5'd0, 16'h0055), enc_i(6'h2B, 5'd1, 5'd0, 16'd8),
             enc_i(6'h23, 5'd2, 5'd0, 16'd8), SYSCALL};
    run_test(10, total);
    check("rerun_r2", m_rf[2], 32'h55);

    $display("[TB] jal word");
    write_im(64, SYSCALL);
    prog = '{32'h0C00_0040};
    run_test(4, total);
`ifdef MIPS_MC_JUMP_EN
    check("jal_r31", m_rf[31], 32'd4);
    check("jal_final_pc", Pc, 32'h104);
`else
    check("jal_nop_pc", Pc, 32'h8);
`endif

    $display("[TB] random programs");
    for (int p = 0; p < 3; p++) begin
      prog = {};
      for (int i = 0; i < 40; i++) prog.push_back(gen_random_instr());
      prog.push_back(SYSCALL);
      run_test(200, total);
      check("rand_halted", 32'(Halted), 32'd1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
